// File: rtl/obi_arb_pkg.sv
// Shared types for the OBI instruction/data memory arbiter: requester IDs and
// arbiter FSM states.
package obi_arb_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered transfers.
// Pops on an empty FIFO are ignored; the arbiter never pushes while full.
module obi_arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_push,
  input  logic i_id,
  input  logic i_pop,
  output logic o_head,
  output logic o_empty,
  output logic o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_ids;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = r_ids[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & ~o_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ids    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wr_ptr] <= i_id;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-requester (instr/data) OBI arbiter onto one memory port with in-order
// response routing. Define ARB_ROUND_ROBIN_EN for round-robin contention.
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_be_i,
  input  logic        data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  arb_state_e  r_state;
  req_id_e     r_lock_id;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
`ifdef ARB_ROUND_ROBIN_EN
  req_id_e     r_last;
`endif

  req_id_e     w_sel;
  req_id_e     w_cur_id;
  logic        w_any;
  logic        w_locked;
  logic        w_full;
  logic        w_empty;
  logic        w_head;
  logic        w_accept;
  logic        w_rsp;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_we;

  assign w_any    = instr_req_i | data_req_i;
  assign w_locked = (r_state == ST_LOCKED);

  always_comb begin
    w_sel = data_req_i ? REQ_DATA : REQ_INSTR;
    if (instr_req_i && data_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_sel = (r_last == REQ_DATA) ? REQ_INSTR : REQ_DATA;
`else
      w_sel = REQ_DATA;
`endif
    end
  end

  always_comb begin
    w_addr  = '0;
    w_be    = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    if (w_any) begin
      if (w_sel == REQ_DATA) begin
        w_addr  = data_addr_i;
        w_be    = data_be_i;
        w_we    = data_we_i;
        w_wdata = data_wdata_i;
      end else begin
        w_addr = instr_addr_i;
        w_be   = INSTR_BE;
      end
    end
  end

  // A stalled request stays committed even if the requester withdraws it.
  assign mem_req_o   = w_locked | (w_any & ~w_full);
  assign w_cur_id    = w_locked ? r_lock_id : w_sel;
  assign mem_addr_o  = w_locked ? r_addr  : w_addr;
  assign mem_be_o    = w_locked ? r_be    : w_be;
  assign mem_we_o    = w_locked ? r_we    : w_we;
  assign mem_wdata_o = w_locked ? r_wdata : w_wdata;

  assign w_accept    = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = w_accept & (w_cur_id == REQ_INSTR);
  assign data_gnt_o  = w_accept & (w_cur_id == REQ_DATA);

  assign w_rsp          = mem_rvalid_i & ~w_empty;
  assign instr_rvalid_o = w_rsp & (w_head == REQ_INSTR);
  assign data_rvalid_o  = w_rsp & (w_head == REQ_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  obi_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_push (w_accept),
    .i_id   (w_cur_id),
    .i_pop  (mem_rvalid_i),
    .o_head (w_head),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_lock_id <= REQ_INSTR;
      r_addr    <= '0;
      r_be      <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last    <= REQ_INSTR;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req_o && !mem_gnt_i) begin
            r_state   <= ST_LOCKED;
            r_lock_id <= w_sel;
            r_addr    <= w_addr;
            r_be      <= w_be;
            r_we      <= w_we;
            r_wdata   <= w_wdata;
          end
        end
        ST_LOCKED: begin
          if (mem_gnt_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      if (w_accept) r_last <= w_cur_id;
`endif
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: directed scenarios then random
// traffic, all compared against a transaction-level model.
module tb_obi_mem_arbiter;

  localparam int MAXO = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic [3:0]  data_be_i = '0;
  logic        data_we_i = 1'b0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  obi_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_be_i(data_be_i),
    .data_we_i(data_we_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of outstanding requester IDs (0=instr, 1=data), plus a
  // transfer that was offered but not yet granted.
  int          q[$];
  bit          m_stuck;
  int          m_sid;
  logic [31:0] m_saddr, m_swdata;
  logic [3:0]  m_sbe;
  logic        m_swe;
  int          m_last;

  logic        e_req, e_we, e_ig, e_dg, e_irv, e_drv;
  int          e_sel;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_stuck = 1'b0;
    m_last  = 0;
  endtask

  task automatic model_eval();
    bit any;
    any = instr_req_i | data_req_i;
    {e_ig, e_dg, e_irv, e_drv} = '0;
    if (m_stuck) begin
      e_req = 1'b1; e_sel = m_sid; e_addr = m_saddr;
      e_be = m_sbe; e_we = m_swe; e_wdata = m_swdata;
    end else begin
      e_req = any && (q.size() < MAXO);
      if (instr_req_i && data_req_i) e_sel = RR ? (m_last == 1 ? 0 : 1) : 1;
      else                           e_sel = data_req_i ? 1 : 0;
      if (!any) begin
        e_addr = '0; e_be = '0; e_we = 1'b0; e_wdata = '0;
      end else if (e_sel == 1) begin
        e_addr = data_addr_i; e_be = data_be_i; e_we = data_we_i; e_wdata = data_wdata_i;
      end else begin
        e_addr = instr_addr_i; e_be = 4'hF; e_we = 1'b0; e_wdata = '0;
      end
    end
    if (e_req && mem_gnt_i) begin
      if (e_sel == 1) e_dg = 1'b1; else e_ig = 1'b1;
    end
    if (mem_rvalid_i && q.size() > 0) begin
      if (q[0] == 1) e_drv = 1'b1; else e_irv = 1'b1;
    end
  endtask

  task automatic model_step();
    if (mem_rvalid_i && q.size() > 0) void'(q.pop_front());
    if (e_req && mem_gnt_i) begin
      q.push_back(e_sel);
      m_last  = e_sel;
      m_stuck = 1'b0;
    end else if (e_req && !m_stuck) begin
      m_stuck = 1'b1; m_sid = e_sel; m_saddr = e_addr;
      m_sbe = e_be; m_swe = e_we; m_swdata = e_wdata;
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
    model_eval();
    chk("mem_req", 32'(mem_req_o), 32'(e_req));
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_be", 32'(mem_be_o), 32'(e_be));
    chk("mem_we", 32'(mem_we_o), 32'(e_we));
    chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("instr_gnt", 32'(instr_gnt_o), 32'(e_ig));
    chk("data_gnt", 32'(data_gnt_o), 32'(e_dg));
    chk("instr_rvalid", 32'(instr_rvalid_o), 32'(e_irv));
    chk("data_rvalid", 32'(data_rvalid_o), 32'(e_drv));
    chk("instr_rdata", instr_rdata_o, mem_rdata_i);
    chk("data_rdata", data_rdata_o, mem_rdata_i);
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (rst_ni) model_step();
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    instr_addr_i = '0; data_addr_i = '0; data_be_i = '0; data_we_i = 0;
    data_wdata_i = '0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    settle();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    settle();
    chk("reset_mem_req", 32'(mem_req_o), 32'd0);
    tick();
    rst_ni = 1'b1;

    // Instruction-only fetch with immediate grant and next-cycle response
    instr_req_i = 1; instr_addr_i = 32'h0010_0000; mem_gnt_i = 1;
    settle();
    chk("fetch_gnt", 32'(instr_gnt_o), 32'd1);
    chk("fetch_addr", mem_addr_o, 32'h0010_0000);
    tick();
    idle_inputs(); mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    settle();
    chk("fetch_rvalid", 32'(instr_rvalid_o), 32'd1);
    chk("fetch_rdata", instr_rdata_o, 32'h0000_0013);
    chk("fetch_no_drv", 32'(data_rvalid_o), 32'd0);
    tick();

    // Simultaneous requests: data first, then instr, responses D then I
    idle_inputs();
    instr_req_i = 1; instr_addr_i = 32'h0000_1000; mem_gnt_i = 1;
    data_req_i = 1; data_addr_i = 32'h0000_2000; data_be_i = 4'h3;
    data_we_i = 1; data_wdata_i = 32'hCAFE_F00D;
    settle();
    chk("both_dgnt", 32'(data_gnt_o), 32'd1);
    chk("both_ignt", 32'(instr_gnt_o), 32'd0);
    tick();
    data_req_i = 0;
    settle();
    chk("both_ignt2", 32'(instr_gnt_o), 32'd1);
    tick();
    idle_inputs(); mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA_0001;
    settle();
    chk("both_rsp1_d", 32'(data_rvalid_o), 32'd1);
    tick();
    mem_rdata_i = 32'hBBBB_0002;
    settle();
    chk("both_rsp2_i", 32'(instr_rvalid_o), 32'd1);
    tick();

    // Stalled instr request keeps its address while data request appears
    idle_inputs();
    instr_req_i = 1; instr_addr_i = 32'h0000_0300;
    settle(); tick();
    data_req_i = 1; data_addr_i = 32'h0000_0400; data_be_i = 4'hC;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_addr", mem_addr_o, 32'h0000_0300);
      tick();
    end
    mem_gnt_i = 1;
    settle();
    chk("stall_ignt", 32'(instr_gnt_o), 32'd1);
    tick();
    instr_req_i = 0;
    settle();
    chk("stall_dgnt", 32'(data_gnt_o), 32'd1);
    chk("stall_daddr", mem_addr_o, 32'h0000_0400);
    tick();
    idle_inputs(); mem_rvalid_i = 1;
    settle(); tick(); settle(); tick();

    // Outstanding limit: third request blocked until a response retires one
    idle_inputs();
    instr_req_i = 1; mem_gnt_i = 1;
    for (int i = 0; i < 2; i++) begin
      instr_addr_i = 32'h0000_0500 + 32'(i * 4);
      settle(); tick();
    end
    instr_addr_i = 32'h0000_0508;
    settle();
    chk("full_req", 32'(mem_req_o), 32'd0);
    tick();
    mem_rvalid_i = 1;
    settle();
    chk("full_pop_req", 32'(mem_req_o), 32'd0);
    tick();
    mem_rvalid_i = 0;
    settle();
    chk("full_rearm_req", 32'(mem_req_o), 32'd1);
    tick();
    idle_inputs(); mem_rvalid_i = 1;
    settle(); tick(); settle(); tick();

    // Reset with one transfer outstanding; its late response is dropped
    idle_inputs();
    instr_req_i = 1; instr_addr_i = 32'h0000_0600; mem_gnt_i = 1;
    settle(); tick();
    idle_inputs();
    do_reset();
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    settle();
    chk("rst_drop_irv", 32'(instr_rvalid_o), 32'd0);
    chk("rst_drop_drv", 32'(data_rvalid_o), 32'd0);
    tick();
    idle_inputs();
    instr_req_i = 1; mem_gnt_i = 1;
    settle(); tick(); settle(); tick();
    settle();
    chk("rst_cnt_full", 32'(mem_req_o), 32'd0);
    tick();
    idle_inputs(); mem_rvalid_i = 1;
    settle(); tick(); settle(); tick();

`ifdef ARB_ROUND_ROBIN_EN
    idle_inputs();
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_order", 32'(data_gnt_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      mem_rvalid_i = 1;
    end
    idle_inputs(); mem_rvalid_i = 1;
    settle(); tick(); settle(); tick();
`endif

    // Random traffic, including upstream protocol violations and resets
    for (int n = 0; n < 3000; n++) begin
      instr_req_i  = ($urandom_range(0, 99) < 50);
      data_req_i   = ($urandom_range(0, 99) < 40);
      instr_addr_i = $urandom;
      data_addr_i  = $urandom;
      data_be_i    = 4'($urandom);
      data_we_i    = 1'($urandom);
      data_wdata_i = $urandom;
      mem_gnt_i    = ($urandom_range(0, 99) < 60);
      mem_rvalid_i = ($urandom_range(0, 99) < 45);
      mem_rdata_i  = $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        settle();
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
